iterative_alu: RTL
==================

# iterative_alu

Parametrised, registered ALU with a valid/ready handshake on both sides. It supports add/sub with carry-in, bitwise logic, logical shifts and an iterative shift-add multiply. The result comes with Z/C/N/V flags held until consumed. It sits between the register-file read stage and write-back in the enhanced processor datapath, and is the successor to the combinational add/sub/AND ALU.

## Interface
- `N`, 16, operand/result width; must be ≥ 4 and a power of 2.
- `SHW`, `$clog2(N)`, shift-amount width (derived; do not override).

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand/op presented.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `x`, `y`  in  N  operands.
- `cin`  in  1  carry-in for ADD/SUB.
- `op`  in  3  operation select.
- `out_valid`  out  1  result/flags valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  N  registered result.
- `z_flag`, `c_flag`, `n_flag`, `v_flag`  out  1 each  registered flags.

## Operation
- Operand capture: accept when `in_valid & in_ready` at a clock edge. x, y, cin and op are captured; later changes to the inputs are ignored.
- Op encoding:
  - 000 ADD: x+y+cin.
  - 001 SUB: x+~y+cin; cin=1 gives a plain subtract, cin=0 a borrow chain.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLL by y[SHW-1:0].
  - 110 SRL by y[SHW-1:0]. Upper y bits are ignored.
  - 111 MUL: low N bits of x*y, unsigned.
- Flags:
  - z = (result==0) for all ops.
  - n = result[N-1] for all ops.
  - c:
    - ADD/SUB: carry out of bit N-1 (SUB: 1 = no borrow).
    - SLL/SRL: last bit shifted out; 0 for a shift of 0.
    - MUL: 1 if the high N bits of the full product are nonzero.
    - Logic ops: 0.
  - v: signed overflow for ADD/SUB, 0 otherwise.
- State machine (states IDLE, MUL, DONE):
  - IDLE → DONE: on accepting any non-MUL op. Result and flags are written on that same edge.
  - IDLE → MUL: on accepting MUL. Load the accumulator with 0, the multiplicand with x, the multiplier with y, and the counter with N-1.
  - MUL: each cycle, if multiplier[0] then add the multiplicand into a 2N-bit accumulator. Then shift the multiplicand left and the multiplier right, and decrement the counter. At counter==0 (after N iterations), write result/flags and go to DONE.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE; `out_valid` drops on the next edge.
- `in_ready` is low in MUL and DONE. `in_valid` in those states is ignored, not queued.
- Reset values (asynchronous, regardless of state): state=IDLE, `out_valid`=0, `result`=0, all flags=0, accumulator/counter=0, `in_ready`=1.
- Reset mid-MUL or in DONE aborts the operation; the pending result is discarded.

## Timing
- Non-MUL latency: accept at edge k, `out_valid` high after edge k (visible in cycle k+1).
- MUL latency: accept at edge k, `out_valid` high after edge k+N.
- Result and flags are stable for the whole time `out_valid`=1.
- Backpressure: DONE holds indefinitely while `out_ready`=0.
- Peak throughput is one non-MUL op per 2 cycles. `out_ready` and `in_ready` are never both effective in the same cycle.
- No combinational path from `in_valid`/`out_ready` to `in_ready`/`out_valid`. `in_ready` decodes state only.

## Structure
- Package `alu_pkg`:
  - Op encoding constants (OP_ADD … OP_MUL).
  - State enum (IDLE, MUL, DONE).
  - Flag index constants.
- Sub-module `alu_adder`: N-bit ripple adder (a, b, cin → sum, cout, plus carry into the MSB for V). Used for ADD/SUB.
- The MUL accumulate uses an inline 2N-bit adder.
- All remaining logic lives in `iterative_alu`.

## Test plan (N=8)
- ADD FF+01, cin=0 → result 00, z=1 c=1 n=0 v=0; `out_valid` in the cycle after accept.
- SUB 80−01, cin=1 → 7F, c=1 v=1 n=0 z=0. SUB 00−01, cin=1 → FF, c=0 n=1.
- MUL 0D×0B → 8F, c=0 n=1; `out_valid` exactly 8 cycles after accept; `in_ready`=0 throughout. MUL 10×10 → 00, z=1 c=1.
- SLL 81 by 1 → 02, c=1. SRL 81 by 3 → 10, c=0. SRL with y=0B (amount 3) → same as by 3.
- Backpressure: hold `out_ready`=0 for 5 cycles after a result and pulse `in_valid` with new operands → result/flags unchanged, new op not accepted. Release → IDLE one cycle later.
- Assert `resetn` low at MUL iteration 4 → `out_valid`/`result`/flags 0 immediately. After release, ADD 05+03 → 08 with correct flags.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared op codes, FSM state type and flag bit positions for
//               iterative_alu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit positions inside the packed {Z,C,N,V} flag vector
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

endpackage

`default_nettype wire

// File: rtl/iterative_alu_if.sv
// ============================================================================
// Module      : iterative_alu_if
// Description : Operand/result handshake bundle between the ALU and its users.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface iterative_alu_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         cin;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         z_flag;
    logic         c_flag;
    logic         n_flag;
    logic         v_flag;

    modport master (
        output in_valid, x, y, cin, op, out_ready,
        input  in_ready, out_valid, result, z_flag, c_flag, n_flag, v_flag
    );

    modport slave (
        input  in_valid, x, y, cin, op, out_ready,
        output in_ready, out_valid, result, z_flag, c_flag, n_flag, v_flag
    );
endinterface

`default_nettype wire

// File: rtl/alu_adder.sv
// ============================================================================
// Module      : alu_adder
// Description : N-bit ripple adder exposing carry-out and carry into the MSB.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    logic w_carry;

    always_comb begin
        sum     = '0;
        c_msb   = 1'b0;
        w_carry = cin;
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) c_msb = w_carry;
            sum[i]  = a[i] ^ b[i] ^ w_carry;
            w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
        end
        cout = w_carry;
    end

endmodule

`default_nettype wire

// File: rtl/iterative_alu.sv
// ============================================================================
// Module      : iterative_alu
// Description : Registered ALU with valid/ready handshake, shifts and an
//               iterative shift-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iterative_alu #(
    parameter int N   = 16,
    parameter int SHW = $clog2(N)
) (
    input  logic             clk,
    input  logic             resetn,
    iterative_alu_if.slave   bus
);
    import alu_pkg::*;

    state_t           r_state, w_state_nxt;
    logic [N-1:0]     r_result;
    logic [3:0]       r_flags;
    logic [2*N-1:0]   r_acc;
    logic [2*N-1:0]   r_mcand;
    logic [N-1:0]     r_mplier;
    logic [SHW-1:0]   r_cnt;

    logic             w_load_alu, w_load_mul, w_mul_done;
    logic [N-1:0]     w_addb, w_sum, w_res;
    logic             w_cout, w_cmsb, w_c, w_v;
    logic [SHW-1:0]   w_amt;
    logic [N:0]       w_sll, w_srl;
    logic [3:0]       w_alu_flags, w_mul_flags;
    logic [2*N-1:0]   w_acc_sum;

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.z_flag    = r_flags[FLAG_Z];
    assign bus.c_flag    = r_flags[FLAG_C];
    assign bus.n_flag    = r_flags[FLAG_N];
    assign bus.v_flag    = r_flags[FLAG_V];

    always_comb begin
        w_state_nxt = r_state;
        w_load_alu  = 1'b0;
        w_load_mul  = 1'b0;
        w_mul_done  = 1'b0;
        case (r_state)
            IDLE: if (bus.in_valid) begin
                if (bus.op == OP_MUL) begin
                    w_state_nxt = MUL;
                    w_load_mul  = 1'b1;
                end else begin
                    w_state_nxt = DONE;
                    w_load_alu  = 1'b1;
                end
            end
            MUL: if (r_cnt == '0) begin
                w_state_nxt = DONE;
                w_mul_done  = 1'b1;
            end
            DONE: if (bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_addb = (bus.op == OP_SUB) ? ~bus.y : bus.y;

    alu_adder #(.N(N)) u_adder (
        .a     (bus.x),
        .b     (w_addb),
        .cin   (bus.cin),
        .sum   (w_sum),
        .cout  (w_cout),
        .c_msb (w_cmsb)
    );

    // Extra bit on each side catches the last bit shifted out (0 for amount 0)
    assign w_amt = bus.y[SHW-1:0];
    assign w_sll = {1'b0, bus.x} << w_amt;
    assign w_srl = {bus.x, 1'b0} >> w_amt;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (bus.op)
            OP_ADD, OP_SUB: begin
                w_res = w_sum;
                w_c   = w_cout;
                w_v   = w_cout ^ w_cmsb;
            end
            OP_AND: w_res = bus.x & bus.y;
            OP_OR:  w_res = bus.x | bus.y;
            OP_XOR: w_res = bus.x ^ bus.y;
            OP_SLL: begin
                w_res = w_sll[N-1:0];
                w_c   = w_sll[N];
            end
            OP_SRL: begin
                w_res = w_srl[N:1];
                w_c   = w_srl[0];
            end
            default: w_res = '0;
        endcase
        w_alu_flags         = '0;
        w_alu_flags[FLAG_Z] = (w_res == '0);
        w_alu_flags[FLAG_C] = w_c;
        w_alu_flags[FLAG_N] = w_res[N-1];
        w_alu_flags[FLAG_V] = w_v;
    end

    assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_mul_flags         = '0;
        w_mul_flags[FLAG_Z] = (w_acc_sum[N-1:0] == '0);
        w_mul_flags[FLAG_C] = |w_acc_sum[2*N-1:N];
        w_mul_flags[FLAG_N] = w_acc_sum[N-1];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_flags  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_alu) begin
                r_result <= w_res;
                r_flags  <= w_alu_flags;
            end
            if (w_load_mul) begin
                r_acc    <= '0;
                r_mcand  <= {{N{1'b0}}, bus.x};
                r_mplier <= bus.y;
                r_cnt    <= SHW'(N - 1);
            end else if (r_state == MUL) begin
                r_acc    <= w_acc_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - 1'b1;
            end
            if (w_mul_done) begin
                r_result <= w_acc_sum[N-1:0];
                r_flags  <= w_mul_flags;
            end
        end
    end

endmodule

`default_nettype wire
